// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and entry-type encodings, also used by the
// register file and reservation stations.
package rob_pkg;

  localparam int ROB_WIDTH = 3;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;
  typedef logic [ROB_WIDTH:0]   rob_cnt_t;

  localparam rob_cnt_t ROB_FULL_CNT = rob_cnt_t'(ROB_SIZE);

  typedef enum logic [1:0] {
    ROB_TYPE_REG = 2'd0,
    ROB_TYPE_BR  = 2'd1,
    ROB_TYPE_ST  = 2'd2
  } rob_type_e;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback on two buses, in-order
// retire at the head (combinational commit, one per cycle); rdy_in low freezes everything.
module rob
  import rob_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic [31:0]          issue_pc,
  input  logic                 issue_pred_jump,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 rob_full,
  input  logic                 alu_valid,
  input  logic [ROB_WIDTH-1:0] alu_rob_id,
  input  logic [31:0]          alu_val,
  input  logic                 alu_jump,
  input  logic [31:0]          alu_target,
  input  logic                 lsb_valid,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_val,
  input  logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic                 search_ready_1,
  output logic                 search_ready_2,
  output logic [31:0]          search_val_1,
  output logic [31:0]          search_val_2,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 commit_store,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  rob_id_t  head, tail;
  rob_cnt_t count;

  logic [ROB_SIZE-1:0] busy, ready, mispred, pred_jump;
  rob_type_e           etype    [ROB_SIZE];
  logic [4:0]          rd       [ROB_SIZE];
  logic [31:0]         pc       [ROB_SIZE];
  logic [31:0]         val      [ROB_SIZE];
  logic [31:0]         redirect [ROB_SIZE];

  logic active, issue_en, commit_en;

  // Nothing moves during a flush cycle or while the core is stalled.
  assign active    = rdy_in && !clear;
  assign rob_full  = (count == ROB_FULL_CNT);
  assign issue_en  = active && issue_valid && !rob_full;
  assign commit_en = active && (count != '0) && busy[head] && ready[head];

  assign issue_rob_id = tail;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      busy     <= '0;
      ready    <= '0;
      mispred  <= '0;
      clear    <= 1'b0;
      clear_pc <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        clear <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (commit_en) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
          if (etype[head] == ROB_TYPE_BR && mispred[head]) begin
            clear    <= 1'b1;
            clear_pc <= redirect[head];
          end
        end
        if (lsb_valid) ready[lsb_rob_id] <= 1'b1;
        if (alu_valid) begin
          ready[alu_rob_id] <= 1'b1;
          if (etype[alu_rob_id] == ROB_TYPE_BR)
            mispred[alu_rob_id] <= (alu_jump != pred_jump[alu_rob_id]);
        end
        if (issue_en) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          mispred[tail] <= 1'b0;
          tail          <= tail + 1'b1;
        end
        count <= count + rob_cnt_t'(issue_en) - rob_cnt_t'(commit_en);
      end
    end
  end

  // Payload storage needs no reset: busy/ready gate every read of it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && active) begin
      if (lsb_valid) val[lsb_rob_id] <= lsb_val;
      if (alu_valid) begin
        val[alu_rob_id] <= alu_val;
        if (etype[alu_rob_id] == ROB_TYPE_BR)
          redirect[alu_rob_id] <= alu_jump ? alu_target : pc[alu_rob_id] + 32'd4;
      end
      if (issue_en) begin
        etype[tail]     <= rob_type_e'(issue_type);
        rd[tail]        <= issue_rd;
        pc[tail]        <= issue_pc;
        pred_jump[tail] <= issue_pred_jump;
        val[tail]       <= '0;
      end
    end
  end

  always_comb begin
    commit_reg_id = '0;
    commit_val    = '0;
    commit_rob_id = '0;
    commit_store  = 1'b0;
    if (commit_en) begin
      commit_rob_id = head;
      if (etype[head] == ROB_TYPE_ST) begin
        commit_store = 1'b1;
      end else begin
        commit_reg_id = rd[head];
        commit_val    = val[head];
      end
    end
  end

  // Returns {ready, value}; a same-cycle writeback bypasses the stored copy.
  function automatic logic [32:0] lookup(input rob_id_t id);
    if (count == '0)                            return '0;
    if (rdy_in && alu_valid && alu_rob_id == id) return {1'b1, alu_val};
    if (rdy_in && lsb_valid && lsb_rob_id == id) return {1'b1, lsb_val};
    if (busy[id])                               return {ready[id], val[id]};
    return {1'b1, 32'd0};
  endfunction

  assign {search_ready_1, search_val_1} = lookup(search_rob_id_1);
  assign {search_ready_2, search_val_2} = lookup(search_rob_id_2);

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_rob;
  import rob_pkg::*;

  logic        clk_in, rst_in, rdy_in;
  logic        issue_valid, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [2:0]  issue_rob_id;
  logic        rob_full;
  logic        alu_valid, alu_jump;
  logic [2:0]  alu_rob_id;
  logic [31:0] alu_val, alu_target;
  logic        lsb_valid;
  logic [2:0]  lsb_rob_id;
  logic [31:0] lsb_val;
  logic [2:0]  search_rob_id_1, search_rob_id_2;
  logic        search_ready_1, search_ready_2;
  logic [31:0] search_val_1, search_val_2;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_val;
  logic [2:0]  commit_rob_id;
  logic        commit_store, clear;
  logic [31:0] clear_pc;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_rob_id(issue_rob_id), .rob_full(rob_full),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .alu_jump(alu_jump), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
    .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
    .search_val_1(search_val_1), .search_val_2(search_val_2),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .commit_store(commit_store),
    .clear(clear), .clear_pc(clear_pc)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of live ids plus per-id payload.
  int          mq[$];
  int          m_tail;
  bit          m_clear;
  logic [31:0] m_cpc;
  logic [1:0]  m_type [8];
  logic [4:0]  m_rd   [8];
  logic [31:0] m_pc   [8];
  logic [31:0] m_val  [8];
  logic [31:0] m_tgt  [8];
  bit          m_pred [8];
  bit          m_jump [8];
  bit          m_rdy  [8];

  function automatic bit in_q(input int id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [32:0] m_search(input int id);
    if (mq.size() == 0)                                   return '0;
    if (rdy_in && alu_valid && int'(alu_rob_id) == id)    return {1'b1, alu_val};
    if (rdy_in && lsb_valid && int'(lsb_rob_id) == id)    return {1'b1, lsb_val};
    if (in_q(id))                                         return {m_rdy[id], m_val[id]};
    return {1'b1, 32'd0};
  endfunction

  function automatic bit m_commit();
    return rdy_in && !m_clear && mq.size() > 0 && m_rdy[mq[0]];
  endfunction

  task automatic model_check();
    bit          cen;
    int          h;
    logic [32:0] s1, s2;
    cen = m_commit();
    h   = cen ? mq[0] : 0;
    s1  = m_search(int'(search_rob_id_1));
    s2  = m_search(int'(search_rob_id_2));
    chk("model_full",     rob_full,       mq.size() == 8);
    chk("model_issue_id", issue_rob_id,   m_tail);
    chk("model_creg",     commit_reg_id,  (cen && m_type[h] != 2'd2) ? m_rd[h] : 5'd0);
    chk("model_cval",     commit_val,     (cen && m_type[h] != 2'd2) ? m_val[h] : 32'd0);
    chk("model_cid",      commit_rob_id,  h);
    chk("model_cstore",   commit_store,   cen && m_type[h] == 2'd2);
    chk("model_s1_rdy",   search_ready_1, s1[32]);
    chk("model_s1_val",   search_val_1,   s1[31:0]);
    chk("model_s2_rdy",   search_ready_2, s2[32]);
    chk("model_s2_val",   search_val_2,   s2[31:0]);
    chk("model_clear",    clear,          m_clear);
    chk("model_clear_pc", clear_pc,       m_cpc);
  endtask

  task automatic model_step();
    bit full;
    int h, id;
    if (rst_in) begin
      mq.delete();
      m_tail  = 0;
      m_clear = 1'b0;
      m_cpc   = '0;
    end else if (rdy_in) begin
      if (m_clear) begin
        m_clear = 1'b0;
        mq.delete();
        m_tail = 0;
      end else begin
        full = (mq.size() == 8);
        if (m_commit()) begin
          h = mq.pop_front();
          if (m_type[h] == 2'd1 && m_jump[h] != m_pred[h]) begin
            m_clear = 1'b1;
            m_cpc   = m_jump[h] ? m_tgt[h] : m_pc[h] + 32'd4;
          end
        end
        if (lsb_valid) begin
          m_rdy[lsb_rob_id] = 1'b1;
          m_val[lsb_rob_id] = lsb_val;
        end
        if (alu_valid) begin
          m_rdy[alu_rob_id] = 1'b1;
          m_val[alu_rob_id] = alu_val;
          if (m_type[alu_rob_id] == 2'd1) begin
            m_jump[alu_rob_id] = alu_jump;
            m_tgt[alu_rob_id]  = alu_target;
          end
        end
        if (issue_valid && !full) begin
          id = m_tail;
          mq.push_back(id);
          m_type[id] = issue_type;
          m_rd[id]   = issue_rd;
          m_pc[id]   = issue_pc;
          m_pred[id] = issue_pred_jump;
          m_jump[id] = issue_pred_jump;
          m_rdy[id]  = 1'b0;
          m_val[id]  = '0;
          m_tail     = (m_tail + 1) % 8;
        end
      end
    end
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = '0; issue_pc = '0; issue_pred_jump = 1'b0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_val = '0; alu_jump = 1'b0; alu_target = '0;
    lsb_valid = 1'b0; lsb_rob_id = '0; lsb_val = '0;
    search_rob_id_1 = '0; search_rob_id_2 = '0;
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    advance();
    rst_in = 1'b0;
    settle();
    chk("rst_full", rob_full, 1'b0);
    chk("rst_id", issue_rob_id, 3'd0);
    chk("rst_creg", commit_reg_id, 5'd0);
    chk("rst_clear", clear, 1'b0);
    chk("rst_clear_pc", clear_pc, 32'd0);
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic [31:0] p, input logic pj);
    issue_valid = 1'b1; issue_type = t; issue_rd = r; issue_pc = p; issue_pred_jump = pj;
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [2:0]  aid;
    logic [31:0] aval;
    logic [2:0]  sid;
    logic [2:0]  e_id;
    logic [4:0]  e_reg;
    logic [31:0] e_val;
    logic [2:0]  e_cid;
    logic        e_sr;
    logic [31:0] e_sv;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic av, logic [2:0] aid,
                              logic [31:0] aval, logic [2:0] sid, logic [2:0] e_id,
                              logic [4:0] e_reg, logic [31:0] e_val, logic [2:0] e_cid,
                              logic e_sr, logic [31:0] e_sv);
    vec_t v;
    v.iv = iv; v.ird = ird; v.av = av; v.aid = aid; v.aval = aval; v.sid = sid;
    v.e_id = e_id; v.e_reg = e_reg; v.e_val = e_val; v.e_cid = e_cid; v.e_sr = e_sr; v.e_sv = e_sv;
    return v;
  endfunction

  vec_t tv[12];

  initial begin
    //            iv rd av aid aval      sid  eid reg val      cid sr sv
    tv[0]  = mk(1, 5, 0, 0, 32'h0,    0,   0,  0,  32'h0,  0,  0, 32'h0);
    tv[1]  = mk(1, 5, 0, 0, 32'h0,    0,   1,  0,  32'h0,  0,  0, 32'h0);
    tv[2]  = mk(1, 5, 0, 0, 32'h0,    5,   2,  0,  32'h0,  0,  1, 32'h0);
    tv[3]  = mk(0, 0, 0, 0, 32'h0,    0,   3,  0,  32'h0,  0,  0, 32'h0);
    tv[4]  = mk(0, 0, 1, 1, 32'h11,   1,   3,  0,  32'h0,  0,  1, 32'h11);
    tv[5]  = mk(0, 0, 1, 0, 32'h10,   1,   3,  0,  32'h0,  0,  1, 32'h11);
    tv[6]  = mk(0, 0, 0, 0, 32'h0,    0,   3,  5,  32'h10, 0,  1, 32'h10);
    tv[7]  = mk(0, 0, 0, 0, 32'h0,    2,   3,  5,  32'h11, 1,  0, 32'h0);
    tv[8]  = mk(0, 0, 0, 0, 32'h0,    2,   3,  0,  32'h0,  0,  0, 32'h0);
    tv[9]  = mk(1, 7, 0, 0, 32'h0,    3,   3,  0,  32'h0,  0,  1, 32'h0);
    tv[10] = mk(0, 0, 1, 3, 32'hABCD, 3,   4,  0,  32'h0,  0,  1, 32'hABCD);
    tv[11] = mk(0, 0, 0, 0, 32'h0,    3,   4,  0,  32'h0,  0,  1, 32'hABCD);

    idle();
    @(negedge clk_in);
    do_reset();

    // Issue, out-of-order writeback, in-order commit, search bypass.
    for (int i = 0; i < 12; i++) begin
      idle();
      if (tv[i].iv) issue(2'd0, tv[i].ird, 32'h1000 + 32'(4 * i), 1'b0);
      alu_valid = tv[i].av; alu_rob_id = tv[i].aid; alu_val = tv[i].aval;
      search_rob_id_1 = tv[i].sid; search_rob_id_2 = ~tv[i].sid;
      settle();
      chk($sformatf("vec%0d_id", i),   issue_rob_id,   tv[i].e_id);
      chk($sformatf("vec%0d_creg", i), commit_reg_id,  tv[i].e_reg);
      chk($sformatf("vec%0d_cval", i), commit_val,     tv[i].e_val);
      chk($sformatf("vec%0d_cid", i),  commit_rob_id,  tv[i].e_cid);
      chk($sformatf("vec%0d_srdy", i), search_ready_1, tv[i].e_sr);
      chk($sformatf("vec%0d_sval", i), search_val_1,   tv[i].e_sv);
      advance();
    end

    // Fill to full, dropped 9th issue, commit at full still blocks issue, then wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); issue(2'd0, 5'(i + 1), 32'h2000 + 32'(4 * i), 1'b0);
      settle(); chk("fill_id", issue_rob_id, 32'(i));
      advance();
    end
    idle(); issue(2'd0, 5'd20, 32'h3000, 1'b0);
    settle(); chk("full_set", rob_full, 1'b1);
    advance();
    idle(); alu_valid = 1'b1; alu_rob_id = 3'd0; alu_val = 32'h77;
    settle(); chk("drop_tail", issue_rob_id, 3'd0); chk("drop_full", rob_full, 1'b1);
    advance();
    idle(); issue(2'd0, 5'd9, 32'h3004, 1'b0);
    settle(); chk("full_commit_creg", commit_reg_id, 5'd1); chk("full_commit_val", commit_val, 32'h77);
    chk("full_commit_still_full", rob_full, 1'b1);
    advance();
    idle(); issue(2'd0, 5'd9, 32'h3008, 1'b0);
    settle(); chk("wrap_full", rob_full, 1'b0); chk("wrap_id", issue_rob_id, 3'd0);
    advance();
    idle(); settle(); chk("wrap_refull", rob_full, 1'b1); chk("wrap_tail", issue_rob_id, 3'd1);
    advance();

    // Mispredicted branch: own rd commits, then a one-cycle clear flushes the rest.
    do_reset();
    idle(); issue(2'd1, 5'd1, 32'h100, 1'b0); settle(); chk("br_id", issue_rob_id, 3'd0); advance();
    idle(); issue(2'd0, 5'd2, 32'h104, 1'b0); advance();
    idle(); issue(2'd0, 5'd3, 32'h108, 1'b0); advance();
    idle();
    alu_valid = 1'b1; alu_rob_id = 3'd0; alu_val = 32'h104; alu_jump = 1'b1; alu_target = 32'h200;
    lsb_valid = 1'b1; lsb_rob_id = 3'd1; lsb_val = 32'h55;
    advance();
    idle(); settle();
    chk("br_commit_rd", commit_reg_id, 5'd1); chk("br_commit_val", commit_val, 32'h104);
    chk("br_commit_id", commit_rob_id, 3'd0); chk("br_no_clear_yet", clear, 1'b0);
    advance();
    idle(); issue(2'd0, 5'd4, 32'h10C, 1'b0); settle();
    chk("clr_pulse", clear, 1'b1); chk("clr_pc", clear_pc, 32'h200);
    chk("clr_no_commit", commit_reg_id, 5'd0);
    advance();
    idle(); search_rob_id_1 = 3'd1; settle();
    chk("post_clr", clear, 1'b0); chk("post_clr_id", issue_rob_id, 3'd0);
    chk("post_clr_full", rob_full, 1'b0); chk("post_clr_empty", search_ready_1, 1'b0);
    advance();

    // Store retire and rdy_in stall with a ready head.
    idle(); issue(2'd2, 5'd9, 32'h400, 1'b0); advance();
    idle(); lsb_valid = 1'b1; lsb_rob_id = 3'd0; lsb_val = 32'hDEAD; advance();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 1'b0; issue(2'd0, 5'd6, 32'h500, 1'b0);
      settle(); chk("stall_store", commit_store, 1'b0); chk("stall_id", issue_rob_id, 3'd1);
      advance();
    end
    idle(); settle();
    chk("st_store", commit_store, 1'b1); chk("st_creg", commit_reg_id, 5'd0); chk("st_cid", commit_rob_id, 3'd0);
    advance();
    idle(); settle(); chk("st_done", commit_store, 1'b0); chk("st_tail", issue_rob_id, 3'd1);
    advance();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int sz;
      idle();
      sz = mq.size();
      rst_in = ($urandom_range(0, 499) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1)
        issue(2'($urandom_range(0, 2)), 5'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
      if (sz > 0 && $urandom_range(0, 1) == 1) begin
        alu_valid = 1'b1; alu_rob_id = 3'(mq[$urandom_range(0, sz - 1)]);
        alu_val = $urandom; alu_jump = 1'($urandom); alu_target = $urandom;
      end
      if (sz > 0 && $urandom_range(0, 1) == 1) begin
        lsb_valid = 1'b1; lsb_rob_id = 3'(mq[$urandom_range(0, sz - 1)]); lsb_val = $urandom;
        if (alu_valid && lsb_rob_id == alu_rob_id && $urandom_range(0, 15) != 0) lsb_valid = 1'b0;
      end
      search_rob_id_1 = 3'($urandom); search_rob_id_2 = 3'($urandom);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rob.md
Name: rob

Overview:
Reorder buffer: a circular queue of in-flight instructions, allocated in order at issue, completed out of order from two writeback buses, and retired in order at the head.
- Sits directly upstream of the register file.
  - Drives the commit triple (reg id, value, ROB id) into it.
  - Answers its two dependency-search ports.
- Sources the global `clear` pulse and redirect PC on a branch mispredict.

Parameters:
- ROB_WIDTH, 3, index width; the buffer holds SIZE = 2^ROB_WIDTH entries.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  low = hold all state; combinational commit outputs forced to 0
- issue_valid  in  1  allocate an entry this cycle
- issue_type  in  2  entry type: REG=0, BR=1, ST=2
- issue_rd  in  5  destination register; 0 = none
- issue_pc  in  32  instruction PC
- issue_pred_jump  in  1  predictor decision for BR entries
- issue_rob_id  out  ROB_WIDTH  tail index, combinational
- rob_full  out  1  count == SIZE
- alu_valid  in  1  ALU writeback strobe
- alu_rob_id  in  ROB_WIDTH  ALU writeback target entry
- alu_val  in  32  ALU result
- alu_jump  in  1  actual taken (BR only)
- alu_target  in  32  actual target (BR only)
- lsb_valid  in  1  load/store-buffer writeback strobe
- lsb_rob_id  in  ROB_WIDTH  LSB writeback target entry
- lsb_val  in  32  load data; stores write back with val ignored
- search_rob_id_1, search_rob_id_2  in  ROB_WIDTH  regfile queries
- search_ready_1, search_ready_2  out  1  queried entry's value is available
- search_val_1, search_val_2  out  32  queried entry's value
- commit_reg_id  out  5  0 when no register commit this cycle
- commit_val  out  32  committed value
- commit_rob_id  out  ROB_WIDTH  head index being retired
- commit_store  out  1  head store retiring; LSB performs the memory write
- clear  out  1  registered one-cycle flush pulse
- clear_pc  out  32  redirect PC, valid while clear = 1

Behaviour:
- Reset:
  - head, tail, count = 0.
  - All entry busy/ready bits = 0.
  - clear = 0, clear_pc = 0.
  - All combinational outputs are 0 while the queue is empty.
- Issue:
  - Accepted when issue_valid && !rob_full && !clear && rdy_in.
  - Entry at tail: busy = 1, ready = 0, fields latched; tail wraps mod SIZE.
  - issue_valid while full is dropped silently; the issuer must check rob_full.
  - rob_full is computed from count before any same-cycle commit, so issue at full is blocked even if the head retires that cycle.
- Writeback:
  - alu_valid or lsb_valid sets ready and stores the value.
  - BR writeback also stores mispredict = (alu_jump != pred_jump) and redirect = alu_jump ? alu_target : pc + 4 (32-bit wrap).
  - Both buses may hit different entries in the same cycle.
  - Same-entry collision is illegal; if it occurs the ALU bus wins.
- Search:
  - ready = (busy && ready) of the queried entry, OR a same-cycle alu/lsb writeback whose id matches (bypass, value from that bus).
  - A non-busy entry returns ready = 1, val = 0; the regfile masks these with its own dependency bit.
- Commit:
  - Combinational from head when count != 0, head ready, rdy_in, !clear.
    - commit_reg_id = rd and commit_val = val for REG/BR.
    - commit_rob_id = head.
    - commit_store = 1 for ST.
  - At the same edge: head advances, busy cleared, count decremented.
  - At most one commit per cycle.
  - Simultaneous issue + commit leaves count unchanged.
- Mispredict:
  - The committing BR with mispredict set registers clear = 1 and clear_pc = redirect for exactly the next cycle.
  - In the clear cycle: no issue or commit; head = tail = count = 0; all busy bits cleared.
  - The branch's own rd still commits in its commit cycle.
- rdy_in low:
  - All registers hold, including a pending clear.
  - Inputs are ignored.
- Reset mid-operation: rst_in overrides everything, including an in-progress clear.
- Wrap-around: the tail index computes as tail + 1 truncated to ROB_WIDTH; full and empty are distinguished by count, which is ROB_WIDTH+1 bits wide.

Decomposition:
- Shared package/defines:
  - ROB_WIDTH (shared with the register file and reservation stations).
  - ROB_TYPE_REG/BR/ST encodings.
- Single module; no sub-module is natural.
- Entry storage is parallel register arrays indexed by ROB id.

Test Plan:
1. Reset, then issue REG rd=5 ×3 → issue_rob_id 0,1,2; count=3; no commit until writeback.
2. Write back id1 (alu_val=0x11), then id0 (0x10) → commits in two consecutive cycles: rd=5/0x10/id0, then rd=5/0x11/id1; id2 still held.
3. Issue 8 entries → rob_full=1; a 9th issue_valid is dropped, tail unchanged; after one commit, rob_full=0 and the next issue gets id0 (wrap).
4. Search id3 in the same cycle as alu writeback of id3 with 0xABCD → search_ready_1=1, search_val_1=0xABCD; next cycle the stored value returns the same result.
5. BR pc=0x100, pred_jump=0, alu_jump=1, target=0x200, rd=1, followed by 2 younger entries → at commit, rd=1 written; next cycle clear=1, clear_pc=0x200; the cycle after, count=0 and issue_rob_id=0.
6. ST entry written back via lsb → commit_store=1, commit_reg_id=0; holding rdy_in low during a ready head → no commit and state unchanged until rdy_in returns.
